// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants and helpers for the seven-segment scan driver.
//   - NUM_DIGITS       : number of multiplexed digits on the display
//   - SEG_0 .. SEG_F   : active-low segment codes {dp,g,f,e,d,c,b,a}, dp off
//   - SEG_BLANK        : all segments off
//   - hex2seg()        : nibble -> active-low 8-bit segment code
//   - lz_blank()       : leading-zero test for one hex digit position
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [2:0] digit_idx_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Hex nibble to active-low segment pattern (decimal point off).
  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = SEG_0;
      4'h1:    code = SEG_1;
      4'h2:    code = SEG_2;
      4'h3:    code = SEG_3;
      4'h4:    code = SEG_4;
      4'h5:    code = SEG_5;
      4'h6:    code = SEG_6;
      4'h7:    code = SEG_7;
      4'h8:    code = SEG_8;
      4'h9:    code = SEG_9;
      4'hA:    code = SEG_A;
      4'hB:    code = SEG_B;
      4'hC:    code = SEG_C;
      4'hD:    code = SEG_D;
      4'hE:    code = SEG_E;
      4'hF:    code = SEG_F;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // A digit is a leading zero when it and every more significant nibble of
  // the 32-bit hex word are zero. Digit 0 always shows, so a value of zero
  // still displays a single "0".
  function automatic logic lz_blank(input logic [31:0] word, input digit_idx_t idx);
    logic [31:0] upper;
    logic        blank;
    upper = word >> {idx, 2'b00};
    if (idx == 3'd0) begin
      blank = 1'b0;
    end else begin
      blank = (upper == 32'd0);
    end
    return blank;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec
//   Combinational hex nibble to 7-segment decoder (active-low, no dp).
//   Ports:
//     i_nib   in  4  hex digit value
//     o_code  out 7  active-low segment code {g,f,e,d,c,b,a}
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_code
);

  // The dp bit of the shared table is dropped; the caller owns the dp.
  assign o_code = 7'(hex2seg(i_nib));

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed 8-digit seven-segment scan driver. A prescaler paces the
//   digit index; the display word and mode are latched once per frame so the
//   source may change at any time without tearing. Segment and anode outputs
//   are registered (one cycle behind the index/data they are computed from).
//   Ports:
//     clk         in   1   system clock
//     rst         in   1   synchronous active-high reset
//     i_data      in   64  display word (hex: [31:0]; raw: 8 segment bytes)
//     disp_mode   in   1   0 = hex nibbles, 1 = raw segment bytes
//     i_blank_lz  in   1   hex mode: blank leading zero digits (sampled live)
//     o_seg       out  8   active-low segments {dp,g,f,e,d,c,b,a}
//     o_sel       out  8   active-low digit anodes, bit0 = rightmost digit
//     o_frame     out  1   one-cycle pulse after each frame-latch load
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_data,
  input  logic        disp_mode,
  input  logic        i_blank_lz,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        o_frame
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam digit_idx_t       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [63:0]      data_q, data_d;
  logic             mode_q, mode_d;
  logic             load_pend_q, load_pend_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       sel_q, sel_d;
  logic             frame_q, frame_d;

  logic             tick_s;
  logic             load_s;
  logic [5:0]       nib_base_s;
  logic [5:0]       byte_base_s;
  logic [3:0]       nib_s;
  logic [6:0]       hex_code_s;
  logic             blank_s;

  assign tick_s = (cnt_q == CNT_LAST);

  // Load at the end of the last digit's slot, or once after reset so the
  // very first scan already shows the live inputs.
  assign load_s = (tick_s && (idx_q == IDX_LAST)) || load_pend_q;

  // Prescaler: counts 0..SCAN_DIV-1 and wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Digit index advances once per prescaler wrap; 3-bit overflow wraps 7->0.
  always_comb begin
    idx_d = idx_q;
    if (tick_s) begin
      idx_d = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // Frame latch: the only place data/mode are captured.
  always_comb begin
    data_d      = data_q;
    mode_d      = mode_q;
    load_pend_d = load_pend_q;
    if (load_s) begin
      data_d      = i_data;
      mode_d      = disp_mode;
      load_pend_d = 1'b0;
    end else begin
      data_d      = data_q;
      mode_d      = mode_q;
      load_pend_d = load_pend_q;
    end
  end

  assign nib_base_s  = {1'b0, idx_q, 2'b00};
  assign byte_base_s = {idx_q, 3'b000};
  assign nib_s       = data_q[nib_base_s +: 4];

  seg7_hex_dec u_hex_dec (
    .i_nib  (nib_s),
    .o_code (hex_code_s)
  );

  // Blank decision uses the latched word but the live blank-enable input.
  always_comb begin
    blank_s = 1'b0;
    if (i_blank_lz && !mode_q) begin
      blank_s = lz_blank(data_q[31:0], idx_q);
    end else begin
      blank_s = 1'b0;
    end
  end

  // Next segment pattern for the digit currently addressed by idx_q.
  always_comb begin
    seg_d = SEG_BLANK;
    if (mode_q) begin
      seg_d = data_q[byte_base_s +: 8];
    end else if (blank_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = {1'b1, hex_code_s};
    end
  end

  // One-hot active-low anode select and the registered frame pulse.
  always_comb begin
    sel_d   = ~(8'b0000_0001 << idx_q);
    frame_d = load_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= {CNT_W{1'b0}};
      idx_q       <= 3'd0;
      data_q      <= 64'd0;
      mode_q      <= 1'b0;
      load_pend_q <= 1'b1;
      seg_q       <= SEG_BLANK;
      sel_q       <= 8'hFF;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      load_pend_q <= load_pend_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      frame_q     <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with SCAN_DIV=4.
// Timeline after reset release: k counts edges with rst low. Output after
// edge k shows digit ((k-1)/4)%8; k=1 still shows pre-load data. o_frame is
// high after edge 1 and after every edge k that is a multiple of 32.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_data;
  logic        disp_mode;
  logic        i_blank_lz;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;
  logic        o_frame;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  logic [7:0] sel_tbl [0:7];

  seg7_scan_ctrl #(.SCAN_DIV(4), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .disp_mode  (disp_mode),
    .i_blank_lz (i_blank_lz),
    .o_seg      (o_seg),
    .o_sel      (o_sel),
    .o_frame    (o_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached got=running want=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    k = k + 1;
  endtask

  task automatic start(input logic [63:0] d, input logic m, input logic b);
    rst = 1'b1; i_data = d; disp_mode = m; i_blank_lz = b;
    step(); step();
    rst = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_data = 64'h0; disp_mode = 1'b0; i_blank_lz = 1'b0;
    repeat (3) step();
    total += 3;
    if (o_seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", o_seg); end
    if (o_sel !== 8'hFF) begin bad++; $display("FAIL reset_sel got=%h want=ff", o_sel); end
    if (o_frame !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", o_frame); end
    rst = 1'b0; k = 0; i_data = 64'h1234ABCD;
    step();
    total += 2;
    if (o_frame !== 1'b1) begin bad++; $display("FAIL release_frame got=%b want=1", o_frame); end
    if (o_sel !== 8'hFE) begin bad++; $display("FAIL release_sel got=%h want=fe", o_sel); end
    step();
    total += 1;
    if (o_frame !== 1'b0) begin bad++; $display("FAIL release_frame2 got=%b want=0", o_frame); end
  endtask

  task automatic test_hex_scan();
    logic [7:0] want [0:7];
    want = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    start(64'h1234ABCD, 1'b0, 1'b0);
    for (int c = 1; c <= 66; c++) begin
      int dg;
      logic fr;
      step();
      dg = ((k - 1) / 4) % 8;
      fr = (k == 1) || (k % 32 == 0);
      total += 1;
      if (o_frame !== fr) begin bad++; $display("FAIL hex_frame k=%0d got=%b want=%b", k, o_frame, fr); end
      if (k >= 2) begin
        total += 2;
        if (o_sel !== sel_tbl[dg]) begin bad++; $display("FAIL hex_sel k=%0d got=%h want=%h", k, o_sel, sel_tbl[dg]); end
        if (o_seg !== want[dg]) begin bad++; $display("FAIL hex_seg k=%0d got=%h want=%h", k, o_seg, want[dg]); end
      end
    end
  endtask

  task automatic test_blank();
    logic [63:0] dat [0:2];
    logic [7:0]  want [0:2][0:7];
    dat = '{64'hA5, 64'h0, 64'hDEADBEEF_0090E0F6};
    want[0] = '{8'h92, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    want[1] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    want[2] = '{8'h82, 8'h8E, 8'hC0, 8'h86, 8'hC0, 8'h90, 8'hFF, 8'hFF};
    for (int s = 0; s < 3; s++) begin
      start(dat[s], 1'b0, 1'b1);
      for (int c = 1; c <= 32; c++) begin
        int dg;
        step();
        dg = ((k - 1) / 4) % 8;
        if (k >= 2) begin
          total += 1;
          if (o_seg !== want[s][dg]) begin
            bad++;
            $display("FAIL blank_seg set=%0d k=%0d got=%h want=%h", s, k, o_seg, want[s][dg]);
          end
        end
      end
    end
  endtask

  task automatic test_raw();
    logic [7:0] want [0:7];
    want = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    start(64'hFFFFFFFEFEFEFEFE, 1'b1, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      int dg;
      step();
      dg = ((k - 1) / 4) % 8;
      if (k >= 2) begin
        total += 2;
        if (o_seg !== want[dg]) begin bad++; $display("FAIL raw_seg k=%0d got=%h want=%h", k, o_seg, want[dg]); end
        if (o_sel !== sel_tbl[dg]) begin bad++; $display("FAIL raw_sel k=%0d got=%h want=%h", k, o_sel, sel_tbl[dg]); end
      end
    end
  endtask

  task automatic test_tearing();
    start(64'h11111111, 1'b0, 1'b0);
    for (int c = 1; c <= 96; c++) begin
      int dg;
      logic [7:0] w;
      logic fr;
      step();
      dg = ((k - 1) / 4) % 8;
      fr = (k == 1) || (k % 32 == 0);
      if (k <= 32) w = 8'hF9;
      else if (k <= 64) w = 8'hA4;
      else if (dg < 4) w = 8'h22;
      else w = 8'h00;
      total += 1;
      if (o_frame !== fr) begin bad++; $display("FAIL tear_frame k=%0d got=%b want=%b", k, o_frame, fr); end
      if (k >= 2) begin
        total += 1;
        if (o_seg !== w) begin bad++; $display("FAIL tear_seg k=%0d got=%h want=%h", k, o_seg, w); end
      end
      // Source changes mid-frame; neither may show before the next boundary.
      if (k == 13) i_data = 64'h22222222;
      if (k == 40) disp_mode = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] want [0:7];
    want = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    start(64'hFFFFFFFF, 1'b0, 1'b0);
    repeat (22) step();
    total += 2;
    if (o_sel !== 8'hDF) begin bad++; $display("FAIL pre_reset_sel got=%h want=df", o_sel); end
    if (o_seg !== 8'h8E) begin bad++; $display("FAIL pre_reset_seg got=%h want=8e", o_seg); end
    rst = 1'b1; i_data = 64'h87654321;
    step();
    total += 3;
    if (o_sel !== 8'hFF) begin bad++; $display("FAIL mid_reset_sel got=%h want=ff", o_sel); end
    if (o_seg !== 8'hFF) begin bad++; $display("FAIL mid_reset_seg got=%h want=ff", o_seg); end
    if (o_frame !== 1'b0) begin bad++; $display("FAIL mid_reset_frame got=%b want=0", o_frame); end
    rst = 1'b0; k = 0;
    for (int c = 1; c <= 32; c++) begin
      int dg;
      step();
      dg = ((k - 1) / 4) % 8;
      if (k == 1) begin
        total += 2;
        if (o_frame !== 1'b1) begin bad++; $display("FAIL resume_frame got=%b want=1", o_frame); end
        if (o_sel !== 8'hFE) begin bad++; $display("FAIL resume_sel got=%h want=fe", o_sel); end
      end else begin
        total += 2;
        if (o_sel !== sel_tbl[dg]) begin bad++; $display("FAIL resume_sel k=%0d got=%h want=%h", k, o_sel, sel_tbl[dg]); end
        if (o_seg !== want[dg]) begin bad++; $display("FAIL resume_seg k=%0d got=%h want=%h", k, o_seg, want[dg]); end
      end
    end
  endtask

  initial begin
    sel_tbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    rst = 1'b1; i_data = 64'h0; disp_mode = 1'b0; i_blank_lz = 1'b0;
    test_reset();
    test_hex_scan();
    test_blank();
    test_raw();
    test_tearing();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
